// File: rtl/dispenser_pkg.sv
// Shared definitions for the pet-food dispense scheduler: FSM encoding,
// parameter legal ranges and the BCD feed-counter helper.
package dispenser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam int TICK_DIV_MIN = 2;
    localparam int TICKS_MIN    = 1;
    localparam int TICKS_MAX    = 15;
    localparam int CNT_W        = 4;

    // Single BCD digit increment; 9 rolls over to 0.
    function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV time-base prescaler: tick is high on the last count of each
// period; clear restarts the period so phases align to state changes.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int             W    = $clog2(DIV);
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/dispense_scheduler.sv
// Feed scheduler: interval-timed and manual feeds, fixed-length motor
// dispense, mandatory cooldown, hopper-empty abort and a BCD feed tally.
module dispense_scheduler
    import dispenser_pkg::*;
#(
    parameter int TICK_DIV       = 4,
    parameter int INTERVAL       = 3,
    parameter int DISPENSE_TICKS = 2,
    parameter int COOLDOWN_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       manual_req,
    input  logic       food_empty,
    output logic       motor_on,
    output logic       busy,
    output logic       feed_done,
    output logic       empty_err,
    output logic [3:0] feed_count,
    output logic [3:0] next_feed
);

    if (TICK_DIV < TICK_DIV_MIN ||
        INTERVAL < TICKS_MIN || INTERVAL > TICKS_MAX ||
        DISPENSE_TICKS < TICKS_MIN || DISPENSE_TICKS > TICKS_MAX ||
        COOLDOWN_TICKS < TICKS_MIN || COOLDOWN_TICKS > TICKS_MAX) begin : g_param_check
        $error("dispense_scheduler: parameter out of range");
    end

    localparam logic [3:0] INTERVAL_L      = 4'(INTERVAL);
    localparam logic [3:0] DISPENSE_LAST   = 4'(DISPENSE_TICKS - 1);
    localparam logic [3:0] COOLDOWN_LAST   = 4'(COOLDOWN_TICKS - 1);

    state_t     state, state_next;
    logic       tick, transition;
    logic       manual_req_d1, manual_pend, manual_edge, sched_due;
    logic       start, feed_ok, abort;
    logic [3:0] phase;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (transition),
        .tick  (tick)
    );

    assign manual_edge = manual_req & ~manual_req_d1;
    assign sched_due   = (next_feed == 4'd0) & enable;
    assign transition  = (state_next != state);

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        feed_ok    = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((manual_edge | manual_pend | sched_due) & ~food_empty) begin
                    state_next = ST_DISPENSE;
                    start      = 1'b1;
                end
            end
            ST_DISPENSE: begin
                // An empty hopper wins over a same-cycle normal completion.
                if (food_empty) begin
                    state_next = ST_COOLDOWN;
                    abort      = 1'b1;
                end else if (tick && phase == DISPENSE_LAST) begin
                    state_next = ST_COOLDOWN;
                    feed_ok    = 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (tick && phase == COOLDOWN_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            manual_req_d1 <= 1'b0;
            manual_pend   <= 1'b0;
            phase         <= 4'd0;
            feed_done     <= 1'b0;
            empty_err     <= 1'b0;
            feed_count    <= 4'd0;
            next_feed     <= INTERVAL_L;
        end else begin
            state         <= state_next;
            manual_req_d1 <= manual_req;
            feed_done     <= feed_ok;

            // Starting a feed consumes every pending request, including a same-cycle edge.
            if (start) begin
                manual_pend <= 1'b0;
            end else if (manual_edge) begin
                manual_pend <= 1'b1;
            end

            if (transition) begin
                phase <= 4'd0;
            end else if (tick && state != ST_IDLE) begin
                phase <= phase + 4'd1;
            end

            if (start) begin
                empty_err <= 1'b0;
            end else if (abort) begin
                empty_err <= 1'b1;
            end

            if (feed_ok) begin
                feed_count <= bcd_inc(feed_count);
            end

            if (start) begin
                next_feed <= INTERVAL_L;
            end else if (state == ST_IDLE && enable && tick && next_feed != 4'd0) begin
                next_feed <= next_feed - 4'd1;
            end
        end
    end

    assign motor_on = (state == ST_DISPENSE);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_dispense_scheduler.sv
// Directed bench for dispense_scheduler at default parameters: a cycle-by-cycle
// vector table plus hand-written schedule, BCD wrap, cooldown and empty-hopper sequences.
module tb_dispense_scheduler;

    logic       clk = 1'b0;
    logic       reset, enable, manual_req, food_empty;
    logic       motor_on, busy, feed_done, empty_err;
    logic [3:0] feed_count, next_feed;

    int checks   = 0;
    int failures = 0;

    dispense_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .manual_req (manual_req),
        .food_empty (food_empty),
        .motor_on   (motor_on),
        .busy       (busy),
        .feed_done  (feed_done),
        .empty_err  (empty_err),
        .feed_count (feed_count),
        .next_feed  (next_feed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, man, emp;
        logic       e_motor, e_busy, e_done, e_err;
        logic [3:0] e_cnt, e_nf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, en, man, emp,
                                input logic e_motor, e_busy, e_done, e_err,
                                input logic [3:0] e_cnt, e_nf);
        vec_t v;
        v.rst = rst; v.en = en; v.man = man; v.emp = emp;
        v.e_motor = e_motor; v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
        v.e_cnt = e_cnt; v.e_nf = e_nf;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic manual_feed();
        bit ok;
        manual_req = 1'b1;
        step();
        manual_req = 1'b0;
        wait_idle(40, ok);
        check("feed_completes", 8'(ok), 8'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; manual_req = 1'b0; food_empty = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit          ok, found;
        int          mcount;
        logic [3:0]  exp_nf[13];

        // Manual feed (N = vec1 cycle), abort in 3rd dispense cycle, reset mid-DISPENSE.
        //            rst en man emp  mot bsy don err cnt nf
        vecs.push_back(mk(1, 0, 0, 0,  0,  0,  0,  0,  0, 3)); // 0 reset
        vecs.push_back(mk(0, 0, 1, 0,  1,  1,  0,  0,  0, 3)); // 1 edge -> DISPENSE
        vecs.push_back(mk(0, 0, 1, 0,  1,  1,  0,  0,  0, 3));
        vecs.push_back(mk(0, 0, 1, 0,  1,  1,  0,  0,  0, 3));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1,  0,  0,  0, 3));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1,  0,  0,  0, 3));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1,  0,  0,  0, 3));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1,  0,  0,  0, 3));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1,  0,  0,  0, 3)); // 8 last motor cycle
        vecs.push_back(mk(0, 0, 0, 0,  0,  1,  1,  0,  1, 3)); // 9 feed_done
        vecs.push_back(mk(0, 0, 0, 0,  0,  1,  0,  0,  1, 3));
        vecs.push_back(mk(0, 0, 0, 0,  0,  1,  0,  0,  1, 3));
        vecs.push_back(mk(0, 0, 0, 0,  0,  1,  0,  0,  1, 3));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0,  0,  1, 3)); // 13 idle
        vecs.push_back(mk(0, 0, 1, 0,  1,  1,  0,  0,  1, 3)); // 14 second feed
        vecs.push_back(mk(0, 0, 1, 0,  1,  1,  0,  0,  1, 3));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1,  0,  0,  1, 3)); // 16 3rd dispense cycle
        vecs.push_back(mk(0, 0, 0, 1,  0,  1,  0,  1,  1, 3)); // 17 abort
        vecs.push_back(mk(0, 0, 0, 0,  0,  1,  0,  1,  1, 3));
        vecs.push_back(mk(0, 0, 0, 0,  0,  1,  0,  1,  1, 3));
        vecs.push_back(mk(0, 0, 0, 0,  0,  1,  0,  1,  1, 3));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0,  1,  1, 3)); // 21 idle, err sticky
        vecs.push_back(mk(0, 0, 1, 0,  1,  1,  0,  0,  1, 3)); // 22 start clears err
        vecs.push_back(mk(0, 0, 0, 0,  1,  1,  0,  0,  1, 3));
        vecs.push_back(mk(1, 0, 0, 0,  0,  0,  0,  0,  0, 3)); // 24 reset mid-DISPENSE
        vecs.push_back(mk(0, 0, 0, 0,  0,  0,  0,  0,  0, 3));

        reset = 1'b1; enable = 1'b0; manual_req = 1'b0; food_empty = 1'b0;
        foreach (vecs[i]) begin
            reset = vecs[i].rst; enable = vecs[i].en;
            manual_req = vecs[i].man; food_empty = vecs[i].emp;
            step();
            check($sformatf("vec%0d_motor_on", i),   8'(motor_on),   8'(vecs[i].e_motor));
            check($sformatf("vec%0d_busy", i),       8'(busy),       8'(vecs[i].e_busy));
            check($sformatf("vec%0d_feed_done", i),  8'(feed_done),  8'(vecs[i].e_done));
            check($sformatf("vec%0d_empty_err", i),  8'(empty_err),  8'(vecs[i].e_err));
            check($sformatf("vec%0d_feed_count", i), 8'(feed_count), 8'(vecs[i].e_cnt));
            check($sformatf("vec%0d_next_feed", i),  8'(next_feed),  8'(vecs[i].e_nf));
        end

        // Scheduled feed: enable from reset release; next_feed 3,2,1,0 then reload.
        do_reset();
        enable = 1'b1;
        exp_nf = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd3};
        for (int k = 0; k < 13; k++) begin
            step();
            check($sformatf("sched%0d_next_feed", k), 8'(next_feed), 8'(exp_nf[k]));
            check($sformatf("sched%0d_motor_on", k),  8'(motor_on),  (k == 12) ? 8'd1 : 8'd0);
        end
        enable = 1'b0;
        wait_idle(40, ok);
        check("sched_feed_idle", 8'(ok), 8'd1);
        check("sched_feed_count", 8'(feed_count), 8'd1);

        // Ten manual feeds: BCD count 1..9 then wraps to 0.
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            manual_feed();
            check($sformatf("bcd_feed%0d", i), 8'(feed_count), 8'(i % 10));
        end

        // Manual edge in COOLDOWN is latched: one IDLE cycle, then a new DISPENSE.
        manual_req = 1'b1;
        step();
        manual_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (feed_done) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("cd_reached", 8'(found), 8'd1);
        manual_req = 1'b1;
        step();
        manual_req = 1'b0;
        check("cd_still_busy", 8'(busy), 8'd1);
        wait_idle(20, ok);
        check("cd_idle_reached", 8'(ok), 8'd1);
        step();
        check("cd_restart_motor", 8'(motor_on), 8'd1);
        wait_idle(40, ok);
        check("cd_restart_done", 8'(feed_count), 8'd2);

        // Manual edge coincident with sched_due: exactly one 8-cycle dispense.
        do_reset();
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (next_feed == 4'd0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("sim_due_reached", 8'(found), 8'd1);
        manual_req = 1'b1;
        step();
        manual_req = 1'b0;
        enable = 1'b0;
        check("sim_motor_start", 8'(motor_on), 8'd1);
        check("sim_next_feed_reload", 8'(next_feed), 8'd3);
        mcount = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (motor_on) mcount++;
        end
        check("sim_motor_cycles", 8'(mcount), 8'd8);
        check("sim_feed_count", 8'(feed_count), 8'd1);

        // Empty hopper in IDLE holds requests; refill starts a single feed.
        do_reset();
        enable = 1'b1;
        food_empty = 1'b1;
        for (int i = 0; i < 20; i++) step();
        manual_req = 1'b1;
        step();
        manual_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("empty_hold_busy", 8'(busy), 8'd0);
        check("empty_hold_next_feed", 8'(next_feed), 8'd0);
        food_empty = 1'b0;
        enable = 1'b0;
        step();
        check("refill_start_motor", 8'(motor_on), 8'd1);
        mcount = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (motor_on) mcount++;
        end
        check("refill_motor_cycles", 8'(mcount), 8'd8);
        check("refill_feed_count", 8'(feed_count), 8'd1);
        check("refill_next_feed", 8'(next_feed), 8'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dispense_scheduler.md
DISPENSE_SCHEDULER -- requirements
Module: dispense_scheduler

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 4, meaning clock cycles per time-base tick (>=2).
REQ-002 The block SHALL have parameter INTERVAL, default 3, meaning ticks between scheduled feeds (1..15).
REQ-003 The block SHALL have parameter DISPENSE_TICKS, default 2, meaning ticks motor stays on per feed (1..15).
REQ-004 The block SHALL have parameter COOLDOWN_TICKS, default 1, meaning ticks of mandatory idle after a feed (1..15).
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic on posedge.
REQ-006 The block SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-007 The block SHALL have port enable, input, 1 bit, meaning that 1 arms the automatic schedule.
REQ-008 The block SHALL have port manual_req, input, 1 bit, meaning debounced feed button; its rising edge is a request.
REQ-009 The block SHALL have port food_empty, input, 1 bit, meaning that 1 indicates the hopper is empty.
REQ-010 The block SHALL have port motor_on, output, 1 bit, meaning dispenser motor drive (registered).
REQ-011 The block SHALL have port busy, output, 1 bit, meaning state is not IDLE.
REQ-012 The block SHALL have port feed_done, output, 1 bit, meaning one-cycle pulse on normal feed completion.
REQ-013 The block SHALL have port empty_err, output, 1 bit, meaning sticky flag set when a feed aborts on food_empty.
REQ-014 The block SHALL have port feed_count, output, 4 bits, meaning completed feeds as a BCD digit 0..9.
REQ-015 The block SHALL have port next_feed, output, 4 bits, meaning ticks remaining until the scheduled feed.

Function
REQ-016 Prescaler: counts 0..TICK_DIV-1 and wraps; tick = 1 for one cycle when count = TICK_DIV-1; cleared to 0 on every state transition.
REQ-017 FSM states: IDLE, DISPENSE, COOLDOWN; motor_on = (state == DISPENSE); busy = (state != IDLE).
REQ-018 Manual edge: manual_req & ~manual_req_d1; an edge in any state sets manual_pend, cleared on the cycle IDLE->DISPENSE.
REQ-019 Schedule: next_feed loads INTERVAL at reset and on IDLE->DISPENSE; decrements on tick while IDLE and enable=1; holds at 0; sched_due = (next_feed == 0) & enable.
REQ-020 IDLE->DISPENSE when (edge | manual_pend | sched_due) & ~food_empty; motor_on is high in the cycle after the condition is true (latency 1).
REQ-021 Simultaneous manual and scheduled requests SHALL produce one feed; both sources are cleared.
REQ-022 With food_empty=1 in IDLE, no start occurs; pending requests are held; next_feed stays at 0.
REQ-023 DISPENSE->COOLDOWN on the tick at which the phase counter = DISPENSE_TICKS-1; motor_on lasts exactly DISPENSE_TICKS*TICK_DIV cycles; feed_done pulses in the first COOLDOWN cycle; feed_count increments, 9 wraps to 0.
REQ-024 food_empty=1 during DISPENSE: next cycle COOLDOWN, empty_err=1, no feed_done, feed_count unchanged.
REQ-025 empty_err clears on the next IDLE->DISPENSE transition.
REQ-026 COOLDOWN->IDLE on the tick at which the phase counter = COOLDOWN_TICKS-1; requests arriving in COOLDOWN are latched, not dropped.
REQ-027 The phase counter is 4 bits and is cleared on every state transition.

Reset
REQ-028 On reset=1 at a clock edge, the block SHALL enter IDLE from any state, including mid-DISPENSE.
REQ-029 On reset, motor_on, busy, feed_done, empty_err, manual_pend, manual_req_d1, the prescaler and the phase counter SHALL be 0.
REQ-030 On reset, feed_count SHALL be 0 and next_feed SHALL be INTERVAL.

Structure
REQ-031 State encoding and parameter range constants SHALL live in shared package dispenser_pkg.
REQ-032 The prescaler SHALL be one sub-module, tick_gen (modulo-TICK_DIV counter with clear input and tick output); FSM, schedule counter and feed counter SHALL stay in dispense_scheduler.

Verification (defaults TICK_DIV=4, INTERVAL=3, DISPENSE_TICKS=2, COOLDOWN_TICKS=1)
REQ-033 manual_req rises at cycle N in IDLE, enable=0 -> motor_on=1 for cycles N+1..N+8; feed_done pulses at N+9; busy=0 from N+13; feed_count 0->1.
REQ-034 enable=1 from reset release, no manual -> next_feed steps 3,2,1,0 on ticks; motor_on rises 1 cycle after the third tick; next_feed reloads to 3.
REQ-035 food_empty=1 at the 3rd cycle of DISPENSE -> motor_on=0 next cycle, empty_err=1, no feed_done, feed_count unchanged.
REQ-036 Ten manual feeds -> feed_count steps 1..9 then 0; a manual edge during COOLDOWN -> new DISPENSE starts the cycle after COOLDOWN ends.
REQ-037 reset=1 during DISPENSE -> next cycle motor_on=0, busy=0, feed_count=0, next_feed=3, empty_err=0.
REQ-038 Manual edge and sched_due in the same cycle -> exactly one 8-cycle DISPENSE; feed_count +1.
